// File: rtl/mod_counter_gen.sv
// Modulo-(MAX+1) up/down counter with preset, wrap/saturate boundary mode,
// cascade carry (en in, tc out) and a saturating wrap-event counter.
module mod_counter_gen #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned MAX   = 211,
  parameter int unsigned WCW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  input  logic             sat,
  input  logic             wrap_clr,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap_p,
  output logic             load_err,
  output logic [WCW-1:0]   wrap_cnt
);

  localparam logic [WIDTH-1:0] MaxV    = WIDTH'(MAX);
  localparam logic [WCW-1:0]   WcntTop = {WCW{1'b1}};

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_p_q, wrap_p_d;
  logic             load_err_q, load_err_d;
  logic [WCW-1:0]   wrap_cnt_q, wrap_cnt_d;

  logic at_max_c;
  logic at_zero_c;

  assign at_max_c  = (out_q == MaxV);
  assign at_zero_c = (out_q == '0);

  // Carry-out depends only on en/dir and the current count, never on sat or load.
  assign tc = en & ((dir & at_max_c) | (~dir & at_zero_c));

  // Next count: load beats enable; boundary handled explicitly so no 2^WIDTH rollover is relied on.
  always_comb begin
    out_d      = out_q;
    wrap_p_d   = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (data > MaxV) begin
        out_d      = MaxV;
        load_err_d = 1'b1;
      end else begin
        out_d = data;
      end
    end else if (en) begin
      if (dir) begin
        if (!at_max_c) begin
          out_d = out_q + WIDTH'(1);
        end else if (!sat) begin
          out_d    = '0;
          wrap_p_d = 1'b1;
        end
      end else begin
        if (!at_zero_c) begin
          out_d = out_q - WIDTH'(1);
        end else if (!sat) begin
          out_d    = MaxV;
          wrap_p_d = 1'b1;
        end
      end
    end
  end

  // Wrap-event counter: clear wins over increment, sticks at all-ones.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_clr) begin
      wrap_cnt_d = '0;
    end else if (wrap_p_d && (wrap_cnt_q != WcntTop)) begin
      wrap_cnt_d = wrap_cnt_q + WCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q      <= '0;
      wrap_p_q   <= 1'b0;
      load_err_q <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      out_q      <= out_d;
      wrap_p_q   <= wrap_p_d;
      load_err_q <= load_err_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign out      = out_q;
  assign wrap_p   = wrap_p_q;
  assign load_err = load_err_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_mod_counter_gen.sv
// Directed bench for mod_counter_gen: default instance, a cascaded upper unit,
// and a full-range (MAX = 2^WIDTH-1) instance.
module tb_mod_counter_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Default instance (lower unit of the cascade)
  logic       reset, en, load, dir, sat, wrap_clr;
  logic [8:0] data;
  logic [8:0] out;
  logic       tc, wrap_p, load_err;
  logic [7:0] wrap_cnt;

  // Upper cascade unit
  logic       h_reset;
  logic [8:0] h_out;
  logic       h_tc, h_wrap_p, h_load_err;
  logic [7:0] h_wrap_cnt;

  // Full-range instance
  logic       f_reset, f_en, f_load, f_dir, f_sat, f_wrap_clr;
  logic [3:0] f_data;
  logic [3:0] f_out;
  logic       f_tc, f_wrap_p, f_load_err;
  logic [1:0] f_wrap_cnt;

  logic       zero1 = 1'b0;
  logic       one1  = 1'b1;
  logic [8:0] zero9 = 9'd0;

  mod_counter_gen #(.WIDTH(9), .MAX(211), .WCW(8)) u_dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .data(data), .dir(dir),
    .sat(sat), .wrap_clr(wrap_clr), .out(out), .tc(tc), .wrap_p(wrap_p),
    .load_err(load_err), .wrap_cnt(wrap_cnt)
  );

  mod_counter_gen #(.WIDTH(9), .MAX(211), .WCW(8)) u_hi (
    .clk(clk), .reset(h_reset), .en(tc), .load(zero1), .data(zero9), .dir(one1),
    .sat(zero1), .wrap_clr(zero1), .out(h_out), .tc(h_tc), .wrap_p(h_wrap_p),
    .load_err(h_load_err), .wrap_cnt(h_wrap_cnt)
  );

  mod_counter_gen #(.WIDTH(4), .MAX(15), .WCW(2)) u_full (
    .clk(clk), .reset(f_reset), .en(f_en), .load(f_load), .data(f_data), .dir(f_dir),
    .sat(f_sat), .wrap_clr(f_wrap_clr), .out(f_out), .tc(f_tc), .wrap_p(f_wrap_p),
    .load_err(f_load_err), .wrap_cnt(f_wrap_cnt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; load = 1'b1; data = 9'd100; en = 1'b0; dir = 1'b0; sat = 1'b0; wrap_clr = 1'b1;
    h_reset = 1'b0;
    f_reset = 1'b0; f_en = 1'b0; f_load = 1'b0; f_data = 4'd0; f_dir = 1'b1; f_sat = 1'b0;
    f_wrap_clr = 1'b0;

    // Reset held with load pending
    step(); step();
    chk("rst_out", 32'(out), 0);
    chk("rst_wcnt", 32'(wrap_cnt), 0);
    chk("rst_wrap_p", 32'(wrap_p), 0);
    chk("rst_load_err", 32'(load_err), 0);
    en = 1'b1; dir = 1'b0; load = 1'b0; wrap_clr = 1'b0; #1;
    chk("rst_tc_down", 32'(tc), 1);
    dir = 1'b1; #1;
    chk("rst_tc_up", 32'(tc), 0);
    reset = 1'b1; en = 1'b0;

    // Load 210, count up through wrap
    load = 1'b1; data = 9'd210; step();
    chk("ld210_out", 32'(out), 210);
    chk("ld210_err", 32'(load_err), 0);
    load = 1'b0; en = 1'b1; dir = 1'b1; sat = 1'b0; #1;
    chk("up_tc_210", 32'(tc), 0);
    step();
    chk("up_out_211", 32'(out), 211);
    chk("up_wp_211", 32'(wrap_p), 0);
    chk("up_tc_211", 32'(tc), 1);
    step();
    chk("up_out_0", 32'(out), 0);
    chk("up_wp_0", 32'(wrap_p), 1);
    chk("up_wcnt_1", 32'(wrap_cnt), 1);
    chk("up_tc_0", 32'(tc), 0);
    step();
    chk("up_out_1", 32'(out), 1);
    chk("up_wp_1", 32'(wrap_p), 0);

    // Load 1, count down saturating
    en = 1'b0; load = 1'b1; data = 9'd1; step();
    load = 1'b0; en = 1'b1; dir = 1'b0; sat = 1'b1; #1;
    chk("dn_tc_1", 32'(tc), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dnsat_out", 32'(out), 0);
      chk("dnsat_wp", 32'(wrap_p), 0);
      chk("dnsat_tc", 32'(tc), 1);
    end
    chk("dnsat_wcnt", 32'(wrap_cnt), 1);

    // Out-of-range preset clamps
    en = 1'b0; load = 1'b1; data = 9'd300; step();
    chk("clamp_out", 32'(out), 211);
    chk("clamp_err", 32'(load_err), 1);
    load = 1'b0; step();
    chk("clamp_out_hold", 32'(out), 211);
    chk("clamp_err_pulse", 32'(load_err), 0);

    // Load wins over en at MAX; tc ignores load
    load = 1'b1; data = 9'd50; en = 1'b1; dir = 1'b1; sat = 1'b0; #1;
    chk("ld_tc", 32'(tc), 1);
    step();
    chk("ld_over_en_out", 32'(out), 50);
    chk("ld_over_en_wp", 32'(wrap_p), 0);
    chk("ld_over_en_wcnt", 32'(wrap_cnt), 1);

    // Saturate up at MAX
    en = 1'b0; data = 9'd211; step();
    load = 1'b0; en = 1'b1; dir = 1'b1; sat = 1'b1; #1;
    chk("upsat_tc", 32'(tc), 1);
    step();
    chk("upsat_out", 32'(out), 211);
    chk("upsat_wp", 32'(wrap_p), 0);

    // Direction change takes effect on the same edge
    dir = 1'b0; sat = 1'b0; step();
    chk("dirchg_dn", 32'(out), 210);
    dir = 1'b1; step();
    chk("dirchg_up", 32'(out), 211);

    // Down wrap from 0
    en = 1'b0; load = 1'b1; data = 9'd0; step();
    load = 1'b0; en = 1'b1; dir = 1'b0; step();
    chk("dnwrap_out", 32'(out), 211);
    chk("dnwrap_wp", 32'(wrap_p), 1);
    chk("dnwrap_wcnt", 32'(wrap_cnt), 2);
    en = 1'b0; step();
    chk("hold_out", 32'(out), 211);
    chk("hold_wp", 32'(wrap_p), 0);

    // Reset aborts a pending wrap, then evaluates from 0
    en = 1'b1; dir = 1'b1; reset = 1'b0; step();
    chk("rstmid_out", 32'(out), 0);
    chk("rstmid_wcnt", 32'(wrap_cnt), 0);
    chk("rstmid_wp", 32'(wrap_p), 0);
    reset = 1'b1; step();
    chk("rstrel_out", 32'(out), 1);
    en = 1'b0; load = 1'b1; data = 9'd300; reset = 1'b0; step();
    chk("rstld_out", 32'(out), 0);
    chk("rstld_err", 32'(load_err), 0);
    reset = 1'b1; load = 1'b0;

    // Free-run from 0: wrap every 212 cycles, wrap_cnt saturates at 255
    en = 1'b1; dir = 1'b1; sat = 1'b0;
    for (int i = 0; i < 254 * 212; i++) step();
    chk("free_wcnt_254", 32'(wrap_cnt), 254);
    for (int i = 0; i < 212; i++) step();
    chk("free_wcnt_255", 32'(wrap_cnt), 255);
    for (int i = 0; i < 212; i++) step();
    chk("free_wcnt_sat", 32'(wrap_cnt), 255);
    chk("free_out", 32'(out), 0);

    // Clear coincident with a wrap
    en = 1'b0; load = 1'b1; data = 9'd211; step();
    load = 1'b0; en = 1'b1; wrap_clr = 1'b1; step();
    chk("clr_wrap_wcnt", 32'(wrap_cnt), 0);
    chk("clr_wrap_wp", 32'(wrap_p), 1);
    wrap_clr = 1'b0; en = 1'b0; load = 1'b1; step();
    load = 1'b0; en = 1'b1; step();
    chk("post_clr_wcnt", 32'(wrap_cnt), 1);

    // Cascade: upper unit advances once per lower wrap
    en = 1'b0; load = 1'b1; data = 9'd0; step();
    chk("casc_hi_rst", 32'(h_out), 0);
    load = 1'b0; en = 1'b1; dir = 1'b1; sat = 1'b0; h_reset = 1'b1;
    begin
      int exp_comb = 0;
      for (int i = 0; i < 700; i++) begin
        step();
        exp_comb++;
        chk("casc_comb", 32'(h_out) * 212 + 32'(out), exp_comb);
      end
    end
    chk("casc_hi", 32'(h_out), 3);
    en = 1'b0;

    // Full-range instance: MAX = 15 in 4 bits
    step();
    chk("full_rst_out", 32'(f_out), 0);
    f_reset = 1'b1; f_load = 1'b1; f_data = 4'd14; step();
    chk("full_ld", 32'(f_out), 14);
    chk("full_ld_err", 32'(f_load_err), 0);
    f_load = 1'b0; f_en = 1'b1; f_dir = 1'b1; step();
    chk("full_15", 32'(f_out), 15);
    chk("full_tc", 32'(f_tc), 1);
    step();
    chk("full_upwrap", 32'(f_out), 0);
    chk("full_upwrap_wp", 32'(f_wrap_p), 1);
    chk("full_wcnt1", 32'(f_wrap_cnt), 1);
    f_dir = 1'b0; step();
    chk("full_dnwrap", 32'(f_out), 15);
    chk("full_wcnt2", 32'(f_wrap_cnt), 2);
    f_dir = 1'b1; step();
    chk("full_wcnt3", 32'(f_wrap_cnt), 3);
    f_dir = 1'b0; step();
    chk("full_wcnt_sat", 32'(f_wrap_cnt), 3);
    chk("full_out15", 32'(f_out), 15);
    f_dir = 1'b1; f_sat = 1'b1; #1;
    chk("full_tc_sat", 32'(f_tc), 1);
    step();
    chk("full_sat_out", 32'(f_out), 15);
    chk("full_sat_wp", 32'(f_wrap_p), 0);
    f_en = 1'b0; f_wrap_clr = 1'b1; step();
    chk("full_clr", 32'(f_wrap_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
